// File: rtl/l2_bank_pkg.sv
// l2_bank_pkg: shared types, latency limits and byte-merge helper for the L2 bank responder
package l2_bank_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte, input logic [7:0] new_byte, input logic en);
    return en ? new_byte : old_byte;
  endfunction
endpackage

// File: rtl/l2_bank_resp_pipe.sv
// l2_bank_resp_pipe: fixed-depth response shift register with asynchronous clear
module l2_bank_resp_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      data[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid[i] <= valid[i-1];
        data[i]  <= data[i-1];
      end
    end
  end
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
endmodule

// File: rtl/l2_bank_responder.sv
// l2_bank_responder: L2 crossbar slave endpoint with byte-enabled SRAM, fixed-latency in-order responses
module l2_bank_responder
  import l2_bank_pkg::*;
#(
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int TAG_WIDTH      = BE_WIDTH,
  parameter int ID_WIDTH       = 9,
  parameter int READ_LATENCY   = 1,
  parameter int INIT_ON_RESET  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [TAG_WIDTH-1:0]      data_wtag_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]      data_r_rtag_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic                      init_done_o
);
  localparam int DEPTH = 2**ADDR_MEM_WIDTH;
  localparam int RW    = ID_WIDTH + DATA_WIDTH + TAG_WIDTH;
  if (TAG_WIDTH != BE_WIDTH) begin : g_tag_chk
    $error("TAG_WIDTH must equal BE_WIDTH");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_lat_chk
    $error("READ_LATENCY out of range 1..4");
  end
  state_t                    state, state_nxt;
  logic [ADDR_MEM_WIDTH-1:0] cnt;
  logic                      ready, accept, load;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [TAG_WIDTH-1:0]      tag_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     merged;
  logic [RW-1:0]             resp_in, resp_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_ON_RESET != 0) ? INIT : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == INIT) ? cnt + 1'b1 : cnt;
    end
  end
  always_comb state_nxt = (state == INIT && &cnt) ? READY : state;
  always_comb ready = (state == READY);
  assign data_gnt_o  = ready;
  assign init_done_o = ready;
  assign accept      = data_req_i & ready;
  assign load        = accept & data_wen_i;
  for (genvar b = 0; b < BE_WIDTH; b++) begin : g_merge
    assign merged[8*b +: 8] = be_merge(mem[data_add_i][8*b +: 8], data_wdata_i[8*b +: 8], data_be_i[b]);
  end
  // init sweep owns the array; requests in INIT never reach it since accept needs READY
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt]     <= '0;
      tag_mem[cnt] <= '0;
    end else if (accept && !data_wen_i) begin
      mem[data_add_i]     <= merged;
      tag_mem[data_add_i] <= (tag_mem[data_add_i] & ~data_be_i) | (data_wtag_i & data_be_i);
    end
  end
  always_comb resp_in = accept ? {data_ID_i, load ? mem[data_add_i] : '0, load ? tag_mem[data_add_i] : '0} : '0;
  l2_bank_resp_pipe #(.DEPTH(READ_LATENCY), .WIDTH(RW)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  (resp_in),
    .out_valid(data_r_valid_o),
    .out_data (resp_out)
  );
  assign {data_r_ID_o, data_r_rdata_o, data_r_rtag_o} = resp_out;
endmodule
